// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encodings for the two-cache memory bus arbiter.
// Mirrors the values the surrounding cache code takes from its global definitions.
package mem_bus_arbiter_pkg;
  localparam int ADDRESSBIT       = 16;
  localparam int BLOCKBYTE        = 4;
  localparam int WORDSIZE         = 8;
  localparam int MEM_ACCESS_DELAY = 3;
  localparam int ARB_TIMEOUT      = 64;

  localparam logic RD             = 1'b0;
  localparam logic WT             = 1'b1;
  localparam logic ACCESS_SUCCESS = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_RESP  = 2'd2,
    ARB_ABORT = 2'd3
  } arbState_t;

  // Requester identity; also the encoding of lastGnt and the bus owner.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant, bit 0 = A, bit 1 = B.
// A tie goes to whichever requester was not granted last.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       reqA,
  input  logic       reqB,
  input  logic       lastGnt,
  output logic [1:0] gnt
);
  assign gnt[0] = reqA & (~reqB | (lastGnt == OWN_B));
  assign gnt[1] = reqB & ~gnt[0];
endmodule

// File: rtl/mem_bus_arbiter.sv
// Serializes block reads/writes from cache A and cache B onto one memory port,
// round-robin on ties, with a BUSY timeout that aborts a stuck access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDRESSBIT,
  parameter int DATA_W  = BLOCKBYTE * WORDSIZE,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              rdwtA,
  input  logic              rdwtB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataA,
  input  logic [DATA_W-1:0] wdataB,
  output logic              doneA,
  output logic              doneB,
  output logic              errA,
  output logic              errB,
  output logic              gntA,
  output logic              gntB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  output logic              mem_req,
  output logic              mem_rdwt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < MEM_ACCESS_DELAY + 2) begin : gBadTimeout
    $error("TIMEOUT shorter than a normal memory access");
  end

  arbState_t        state, stateNext;
  logic             owner, ownerNext, lastGnt;
  logic [1:0]       pick;
  logic [CNT_W-1:0] toCnt, toCntInc;
  logic             expire, memOk;

  rr_pick2 uPick (
    .reqA    (reqA),
    .reqB    (reqB),
    .lastGnt (lastGnt),
    .gnt     (pick)
  );

  assign memOk     = (mem_done == ACCESS_SUCCESS);
  assign toCntInc  = (toCnt == CNT_W'(TIMEOUT)) ? toCnt : toCnt + 1'b1;
  assign expire    = (toCntInc == CNT_W'(TIMEOUT));
  assign ownerNext = (state == ARB_IDLE) ? pick[1] : owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= stateNext;
  end

  // mem_done wins over a same-cycle expiry.
  always_comb begin
    stateNext = state;
    case (state)
      ARB_IDLE:  if (|pick) stateNext = ARB_BUSY;
      ARB_BUSY:  begin
        if (memOk)       stateNext = ARB_RESP;
        else if (expire) stateNext = ARB_ABORT;
      end
      ARB_RESP:  stateNext = ARB_IDLE;
      ARB_ABORT: stateNext = ARB_IDLE;
      default:   stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_A;
      lastGnt   <= OWN_B;
      toCnt     <= '0;
      doneA     <= 1'b0;
      doneB     <= 1'b0;
      errA      <= 1'b0;
      errB      <= 1'b0;
      gntA      <= 1'b0;
      gntB      <= 1'b0;
      rdataA    <= '0;
      rdataB    <= '0;
      mem_req   <= 1'b0;
      mem_rdwt  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Status outputs are decoded from the next state so they stay registered.
      doneA <= (stateNext == ARB_RESP)  && (owner == OWN_A);
      doneB <= (stateNext == ARB_RESP)  && (owner == OWN_B);
      errA  <= (stateNext == ARB_ABORT) && (owner == OWN_A);
      errB  <= (stateNext == ARB_ABORT) && (owner == OWN_B);
      gntA  <= (stateNext != ARB_IDLE)  && (ownerNext == OWN_A);
      gntB  <= (stateNext != ARB_IDLE)  && (ownerNext == OWN_B);
      case (state)
        ARB_IDLE: if (|pick) begin
          owner     <= pick[1];
          lastGnt   <= pick[1];
          toCnt     <= '0;
          mem_req   <= 1'b1;
          mem_rdwt  <= pick[1] ? rdwtB  : rdwtA;
          mem_addr  <= pick[1] ? addrB  : addrA;
          mem_wdata <= pick[1] ? wdataB : wdataA;
        end
        ARB_BUSY: begin
          toCnt <= toCntInc;
          if (memOk) begin
            mem_req <= 1'b0;
            if (mem_rdwt == RD) begin
              if (owner == OWN_B) rdataB <= mem_rdata;
              else                rdataA <= mem_rdata;
            end
          end else if (expire) begin
            mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: memory stub with 3-cycle delay,
// vector table plus hand sequences, completions checked against a scoreboard.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int DLY = 3;

  logic        clk, rst;
  logic        reqA, reqB, rdwtA, rdwtB;
  logic [15:0] addrA, addrB;
  logic [31:0] wdataA, wdataB;
  logic        doneA, doneB, errA, errB, gntA, gntB;
  logic [31:0] rdataA, rdataB;
  logic        mem_req, mem_rdwt;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_done;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .reqB(reqB), .rdwtA(rdwtA), .rdwtB(rdwtB),
    .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
    .doneA(doneA), .doneB(doneB), .errA(errA), .errB(errB),
    .gntA(gntA), .gntB(gntB), .rdataA(rdataA), .rdataB(rdataB),
    .mem_req(mem_req), .mem_rdwt(mem_rdwt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub
  logic [31:0] mem [256];
  logic [7:0]  stubCnt;
  logic        stubHang, lateDone, loadMem;

  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h00] <= 32'hDEAD_0000;
      mem[8'h40] <= 32'h0000_A5A5;
      mem[8'h44] <= 32'h1111_0044;
      mem[8'h48] <= 32'h2222_0048;
    end else if (mem_req && mem_done && mem_rdwt == WT) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    stubCnt <= mem_req ? stubCnt + 8'd1 : 8'd0;
  end
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_done  = lateDone | (mem_req && stubCnt == 8'(DLY) && !stubHang);

  // Scoreboard
  typedef struct { bit who; bit isErr; logic [31:0] rdata; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compl(input bit who, input bit isErr, input logic [31:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_completion who=%0d err=%0d t=%0t", who, isErr, $time);
    end else begin
      e = sb.pop_front();
      chk("cmp_who",   {31'b0, who},   {31'b0, e.who});
      chk("cmp_err",   {31'b0, isErr}, {31'b0, e.isErr});
      chk("cmp_rdata", rd, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (doneA || errA) compl(1'b0, errA, rdataA);
    if (doneB || errB) compl(1'b1, errB, rdataB);
    if (mem_req) chk("gnt_onehot", {31'b0, gntA ^ gntB}, 32'd1);
  end

  typedef struct {
    bit useA, useB, rdwtA, rdwtB;
    logic [15:0] addrA, addrB;
    logic [31:0] wdA, wdB;
    bit firstB;
    logic [31:0] expA, expB;
    bit hang;
    int lat;
  } vec_t;

  task automatic runVec(input vec_t v);
    int n, nDone;
    bit pendA, pendB;
    @(negedge clk);
    stubHang = v.hang;
    reqA = v.useA; rdwtA = v.rdwtA; addrA = v.addrA; wdataA = v.wdA;
    reqB = v.useB; rdwtB = v.rdwtB; addrB = v.addrB; wdataB = v.wdB;
    if (v.useA && v.useB && v.firstB) sb.push_back('{1'b1, 1'b0, v.expB});
    if (v.useA) sb.push_back('{1'b0, v.hang, v.expA});
    if (v.useB && !(v.useA && v.firstB)) sb.push_back('{1'b1, v.hang, v.expB});
    pendA = v.useA; pendB = v.useB; n = 0; nDone = 0;
    while ((pendA || pendB) && n < 60) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) begin
        chk("first_gntA", {31'b0, gntA}, {31'b0, v.useA && !(v.useB && v.firstB)});
        chk("first_gntB", {31'b0, gntB}, {31'b0, v.useB && (!v.useA || v.firstB)});
      end
      if (doneA || errA || doneB || errB) begin
        nDone++;
        if (nDone == 1) chk("latency_first", n, v.lat);
        else            chk("latency_second", n, v.lat + 6);
      end
      if (doneA || errA) begin reqA = 1'b0; pendA = 1'b0; end
      if (doneB || errB) begin reqB = 1'b0; pendB = 1'b0; end
    end
    if (pendA || pendB) begin
      checks++; failures++;
      $display("FAIL vec_timeout act=pending exp=complete t=%0t", $time);
    end
    reqA = 1'b0; reqB = 1'b0; stubHang = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  vec_t v1;
  int   n, doneAt, gntBAt;

  initial begin
    //          useA useB rdA rdB addrA   addrB   wdA           wdB           fB expA          expB          hang lat
    tbl[0] = '{1, 1, RD, RD, 16'h44, 16'h48, 32'h0,        32'h0,        0, 32'h1111_0044, 32'h2222_0048, 0, 5};
    tbl[1] = '{1, 0, WT, RD, 16'h80, 16'h00, 32'h0000_1234, 32'h0,       0, 32'h1111_0044, 32'h0,        0, 5};
    tbl[2] = '{1, 1, RD, RD, 16'h40, 16'h80, 32'h0,        32'h0,        1, 32'h0000_A5A5, 32'h0000_1234, 0, 5};
    tbl[3] = '{0, 1, RD, WT, 16'h00, 16'h48, 32'h0,        32'hCAFE_0001, 0, 32'h0,        32'h0000_1234, 0, 5};
    tbl[4] = '{1, 0, RD, RD, 16'h48, 16'h00, 32'h0,        32'h0,        0, 32'hCAFE_0001, 32'h0,        0, 5};
    tbl[5] = '{1, 0, RD, RD, 16'h44, 16'h00, 32'h0,        32'h0,        0, 32'hCAFE_0001, 32'h0,        1, 9};
    tbl[6] = '{0, 1, RD, RD, 16'h00, 16'h44, 32'h0,        32'h0,        0, 32'h0,        32'h1111_0044, 0, 5};

    rst = 1'b1; loadMem = 1'b1; stubHang = 1'b0; lateDone = 1'b0;
    reqA = 0; reqB = 0; rdwtA = RD; rdwtB = RD;
    addrA = '0; addrB = '0; wdataA = '0; wdataB = '0;
    repeat (2) @(negedge clk);
    loadMem = 1'b0; rst = 1'b0;

    // Reset state
    chk("rst_doneA", {31'b0, doneA}, 0);   chk("rst_doneB", {31'b0, doneB}, 0);
    chk("rst_errA",  {31'b0, errA},  0);   chk("rst_errB",  {31'b0, errB},  0);
    chk("rst_gntA",  {31'b0, gntA},  0);   chk("rst_gntB",  {31'b0, gntB},  0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_rdwt", {31'b0, mem_rdwt}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdataA", rdataA, 0);          chk("rst_rdataB", rdataB, 0);

    // Single read by A straight out of reset
    v1 = '{1, 0, RD, RD, 16'h40, 16'h00, 32'h0, 32'h0, 0, 32'h0000_A5A5, 32'h0, 0, 5};
    runVec(v1);
    chk("s1_rdataB_untouched", rdataB, 0);

    // Table run starts from reset so the first tie goes to A
    doReset();
    for (int i = 0; i < 7; i++) runVec(tbl[i]);

    // B requests while A writes; B must wait until A's done plus one IDLE cycle
    @(negedge clk);
    reqA = 1; rdwtA = WT; addrA = 16'hC0; wdataA = 32'h0000_5678;
    sb.push_back('{1'b0, 1'b0, 32'hCAFE_0001});
    sb.push_back('{1'b1, 1'b0, 32'h0000_5678});
    @(posedge clk); @(negedge clk);
    chk("s3_gntA", {31'b0, gntA}, 1);
    chk("s3_mem_rdwt", {31'b0, mem_rdwt}, {31'b0, WT});
    chk("s3_mem_addr", {16'b0, mem_addr}, 32'hC0);
    chk("s3_mem_wdata", mem_wdata, 32'h0000_5678);
    reqB = 1; rdwtB = RD; addrB = 16'hC0;
    n = 0; doneAt = -1; gntBAt = -1;
    while (n < 40 && reqB) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (gntB && gntBAt < 0) gntBAt = n;
      if (doneA) begin reqA = 0; doneAt = n; end
      if (doneB) reqB = 0;
    end
    chk("s3_b_done", {31'b0, reqB}, 0);
    chk("s3_b_grant_gap", gntBAt - doneAt, 2);

    // Reset in the middle of A's access
    @(negedge clk);
    reqA = 1; rdwtA = RD; addrA = 16'h40;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("s5_busy_before_rst", {31'b0, mem_req}, 1);
    rst = 1'b1;
    #1;
    chk("s5_mem_req_async_drop", {31'b0, mem_req}, 0);
    chk("s5_gntA_drop", {31'b0, gntA}, 0);
    reqA = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lateDone = 1'b1;
    @(posedge clk); @(negedge clk);
    lateDone = 1'b0;
    chk("s5_late_done_gntA", {31'b0, gntA}, 0);
    chk("s5_late_done_mem_req", {31'b0, mem_req}, 0);
    chk("s5_late_done_rdataA", rdataA, 0);
    repeat (2) @(negedge clk);
    runVec(v1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares one single-port block memory between cache A and cache B. It serializes their block reads and writes so the two caches can never access memory in the same cycle. It applies round-robin priority, holds a stable request on the memory side until the memory reports completion, and returns a one-cycle completion pulse (with read data) to the winning cache. It also aborts any access the memory never completes.

## Interface
- `ADDR_W`, default `ADDRESSBIT`: block/byte address width, forwarded unmodified.
- `DATA_W`, default `BLOCKBYTE*WORDSIZE`: block data width.
- `TIMEOUT`, default 64: maximum cycles in BUSY before the access is aborted (≥ `MEM_ACCESS_DELAY`+2).

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqA`, `reqB` in 1: request level, held until the matching `done`.
- `rdwtA`, `rdwtB` in 1: `RD` or `WT`, from `global_def.v`.
- `addrA`, `addrB` in `ADDR_W`: request address.
- `wdataA`, `wdataB` in `DATA_W`: write block.
- `doneA`, `doneB` out 1: one-cycle completion pulse.
- `errA`, `errB` out 1: one-cycle timeout-abort pulse.
- `gntA`, `gntB` out 1: level, high while that requester owns the bus (BUSY and RESP/ABORT).
- `rdataA`, `rdataB` out `DATA_W`: last read block for each requester, held between reads.
- `mem_req` out 1: memory request level.
- `mem_rdwt` out 1: memory read/write select.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write block.
- `mem_rdata` in `DATA_W`: memory read block.
- `mem_done` in 1: memory completion, treated as `ACCESS_SUCCESS`; a 1-cycle pulse or a level.

## Operation
- FSM states:
  - IDLE → BUSY on any sampled request.
  - BUSY → RESP on `mem_done`.
  - BUSY → ABORT when the timeout counter reaches `TIMEOUT`.
  - RESP → IDLE, unconditionally.
  - ABORT → IDLE, unconditionally.
- Arbitration happens in IDLE only:
  - Only one request high: grant it.
  - Both high: grant the requester that is not `last_gnt`.
  - `last_gnt` updates on every grant.
- On grant, the winner's `rdwt`/`addr`/`wdata` are latched into `mem_*` registers. `mem_req` goes to 1 and stays 1 for all of BUSY.
- Requester inputs are ignored after latching. The non-granted request stays pending, with no loss and no starvation: it always wins the next IDLE.
- On `mem_done` in BUSY:
  - If RD, `mem_rdata` is captured into the owner's `rdata`.
  - `mem_req` drops to 0 entering RESP.
- RESP: the owner's `done`=1 for exactly one cycle.
- ABORT: the owner's `err`=1 for exactly one cycle. `rdata` is unchanged and `mem_req`=0.
- Timeout counter:
  - Width `$clog2(TIMEOUT+1)`.
  - Cleared on entering BUSY, incremented each BUSY cycle, saturating.
  - If `mem_done` and expiry fall in the same cycle, `mem_done` wins and the FSM goes to RESP.
- `mem_done` outside BUSY is ignored.
- Requester contract: it deasserts `req` on the edge where it samples `done` or `err`. A `req` still high in IDLE is a new request.
- Reset:
  - State IDLE, `last_gnt`=B (so A wins the first tie).
  - All `done`/`err`/`gnt`/`mem_req`/`mem_rdwt` = 0.
  - `mem_addr`, `mem_wdata`, `rdataA`, `rdataB`, counter = 0.
- Reset mid-access: `mem_req` drops immediately (asynchronously). The access is dropped with no `done` or `err`, and the requester must re-issue it.

## Timing
- Request high before edge 0 in IDLE → `gnt` and `mem_req` high after edge 0.
- `mem_done` sampled at edge k → `done` (and `rdata`) valid after edge k, for one cycle → IDLE after edge k+1.
- Minimum occupancy is 3 cycles (grant, one BUSY cycle, RESP); there is no back-to-back grant without an IDLE cycle.
- With a memory delay of D cycles after `mem_req`, request-to-`done` latency is D+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `RD`, `WT`, `ACCESS_SUCCESS`, `ACCESSING`, `ADDRESSBIT`, `BLOCKBYTE`, `WORDSIZE` and `MEM_ACCESS_DELAY` come from `global_def.v`.
- Add to `global_def.v`: the FSM state encodings `ARB_IDLE`, `ARB_BUSY`, `ARB_RESP`, `ARB_ABORT` (2 bits), and `ARB_TIMEOUT` (default 64).
- One sub-module, `rr_pick2`: a 2-way round-robin selector taking `reqA`, `reqB` and `last_gnt`, and producing a one-hot grant. It is combinational and instantiated once.
- Everything else (FSM, latches, timeout counter) stays in `mem_bus_arbiter`.

## Test plan
Memory stub returns `mem_done` 3 cycles after `mem_req` rises.
1. After reset, `reqA` RD with addr=0x40, stub data=0xA5A5 → `gntA` 1 cycle later; `doneA` pulses 5 cycles after request; `rdataA`=0xA5A5; `rdataB` stays 0.
2. `reqA` and `reqB` both set in the same cycle → A is served first. B is granted in the IDLE cycle after `doneA`. A second simultaneous pair is served B first.
3. `reqA` WT addr=0x80 data=0x1234, then `reqB` RD addr=0x80 while A is BUSY → `mem_wdata`=0x1234 for A. B is granted only after `doneA` and reads 0x1234 from the stub.
4. Stub never asserts `mem_done` with `TIMEOUT`=8 → `errA` pulses after 8 BUSY cycles; `doneA`=0; `rdataA` unchanged; a following `reqB` completes normally.
5. `rst` pulsed during BUSY of A → `mem_req` falls before the next edge; no `doneA`/`errA`. A re-issued `reqA` completes; a late stub `mem_done` in IDLE is ignored.
